// File: rtl/issue_pkg.sv
// issue_pkg: shared opcodes, instruction field positions and hazard helper functions
package issue_pkg;
    localparam logic [5:0]  OP_LD   = 6'b010100;
    localparam logic [5:0]  OP_ST   = 6'b010101;
    localparam logic [31:0] NOP_INS = 32'b0;
    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RW_HI = 25, RW_LO = 21;
    localparam int RA_HI = 20, RA_LO = 16;
    localparam int RB_HI = 15, RB_LO = 11;

    function automatic logic uses_rb(input logic [5:0] op);
        return op[5:3] == 3'b000;
    endfunction

    // True when rw is read by instruction i (RA always, RB for register ops, RW for stores)
    function automatic logic src_match(input logic [31:0] i, input logic [4:0] rw);
        return (i[RA_HI:RA_LO] == rw)
            || (uses_rb(i[OP_HI:OP_LO]) && i[RB_HI:RB_LO] == rw)
            || (i[OP_HI:OP_LO] == OP_ST && i[RW_HI:RW_LO] == rw);
    endfunction
endpackage

// File: rtl/issue_ctrl_fifo.sv
// ins_fifo: synchronous 32-bit instruction FIFO
//   clk/reset : clock, synchronous active-high reset (clears pointers and count)
//   push/din  : write din when not full
//   pop/dout  : dout shows the head; pop advances it when not empty
//   count/full/empty : occupancy status
module ins_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [31:0]             din,
    output logic [31:0]             dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push_en, pop_en;

    assign push_en = push & !full;
    assign pop_en  = pop & !empty;
    // DEPTH is a power of two, so the count MSB alone marks full
    assign full    = count[AW];
    assign empty   = count == '0;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (push_en) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_en) wp <= wp + 1'b1;
            if (pop_en) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        end
    end
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: buffers fetched instructions and issues one per cycle, inserting one bubble per load-use hazard
//   clk/reset          : clock, synchronous active-high reset
//   in_ins/in_valid    : fetched instruction and its valid
//   in_ready           : FIFO has room
//   mem_busy           : freezes issue
//   flush              : discards buffered instructions and pending issue state
//   ins/ins_valid      : registered instruction to the dependency module
//   bubble             : registered hazard-NOP marker
//   stall_cnt          : saturating hazard bubble count
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_ins,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mem_busy,
    input  logic             flush,
    output logic [31:0]      ins,
    output logic             ins_valid,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]   head;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, adv, hazard, last_ld;
    logic [4:0]    last_rw;

    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid & !full & !flush;
    assign adv      = !mem_busy & !flush;
    assign hazard   = last_ld & (last_rw != 5'd0) & src_match(head, last_rw);
    assign pop      = adv & !empty & !hazard;

    ins_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset | flush),
        .push  (push),
        .pop   (pop),
        .din   (in_ins),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
            bubble    <= 1'b0;
            stall_cnt <= '0;
            last_ld   <= 1'b0;
            last_rw   <= 5'd0;
        end else if (flush) begin
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
            bubble    <= 1'b0;
            last_ld   <= 1'b0;
            last_rw   <= 5'd0;
        end else if (!mem_busy) begin
            if (pop) begin
                ins       <= head;
                ins_valid <= 1'b1;
                bubble    <= 1'b0;
                last_ld   <= head[OP_HI:OP_LO] == OP_LD;
                last_rw   <= head[RW_HI:RW_LO];
            end else begin
                // Either a hazard bubble or nothing to issue; clearing last_ld lets the held head go next
                ins       <= NOP_INS;
                ins_valid <= 1'b0;
                bubble    <= !empty;
                last_ld   <= 1'b0;
                if (!empty) stall_cnt <= (&stall_cnt) ? stall_cnt : stall_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: scoreboard bench for issue_ctrl
module tb_issue_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] in_ins = 0;
    logic        in_valid = 0;
    logic        mem_busy = 0;
    logic        flush = 0;
    logic        in_ready, ins_valid, bubble;
    logic [31:0] ins;
    logic [15:0] stall_cnt;
    logic        in_ready_s, ins_valid_s, bubble_s;
    logic [31:0] ins_s;
    logic [1:0]  stall_cnt_s;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_ins(in_ins), .in_valid(in_valid), .in_ready(in_ready),
        .mem_busy(mem_busy), .flush(flush), .ins(ins), .ins_valid(ins_valid),
        .bubble(bubble), .stall_cnt(stall_cnt)
    );

    issue_ctrl #(.DEPTH(4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_ins(in_ins), .in_valid(in_valid), .in_ready(in_ready_s),
        .mem_busy(mem_busy), .flush(flush), .ins(ins_s), .ins_valid(ins_valid_s),
        .bubble(bubble_s), .stall_cnt(stall_cnt_s)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rw,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rw, ra, rb, 11'b0};
    endfunction

    // Advances one clock; every instruction newly issued on an advance edge is popped from the scoreboard
    task automatic tick();
        logic adv;
        logic [31:0] e;
        adv = !mem_busy && !flush && !reset;
        @(posedge clk);
        #1;
        if (adv && ins_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_order got=%h expected=none", ins);
            end else begin
                e = exp_q.pop_front();
                if (ins !== e) begin
                    failures++;
                    $display("FAIL issue_order got=%h expected=%h", ins, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_ins = 32'hFFFFFFFF;
        tick(); tick();
        reset = 0; in_valid = 0;
        checks++;
        if (ins !== 32'b0 || ins_valid !== 1'b0 || bubble !== 1'b0 || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got ins=%h v=%b b=%b cnt=%0d rdy=%b expected 0/0/0/0/1",
                     ins, ins_valid, bubble, stall_cnt, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ins_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle got ins_valid=%b expected 0", ins_valid);
            end
        end
    endtask

    // Pushes a then b back to back; checks for exactly one bubble when hz is set
    task automatic run_pair(input string name, input logic [31:0] a, input logic [31:0] b, input logic hz);
        in_valid = 1; in_ins = a; exp_q.push_back(a);
        tick();
        in_ins = b; exp_q.push_back(b);
        tick();
        in_valid = 0;
        tick();
        if (hz) begin
            exp_stall++;
            checks++;
            if (ins !== 32'b0 || ins_valid !== 1'b0 || bubble !== 1'b1) begin
                failures++;
                $display("FAIL %s_bubble got ins=%h v=%b b=%b expected 0/0/1", name, ins, ins_valid, bubble);
            end
            tick();
        end
        checks++;
        if (ins_valid !== 1'b1 || bubble !== 1'b0) begin
            failures++;
            $display("FAIL %s_issue got v=%b b=%b expected 1/0", name, ins_valid, bubble);
        end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            failures++;
            $display("FAIL %s_stall_cnt got=%0d expected=%0d", name, stall_cnt, exp_stall);
        end
        tick();
    endtask

    task automatic test_independent();
        run_pair("indep", mk(6'b000000, 5'd1, 5'd2, 5'd3), mk(6'b000100, 5'd5, 5'd1, 5'd4), 1'b0);
    endtask

    task automatic test_load_use();
        run_pair("ld_ra", mk(6'b010100, 5'd4, 5'd1, 5'd0), mk(6'b000000, 5'd5, 5'd4, 5'd2), 1'b1);
        run_pair("ld_rb", mk(6'b010100, 5'd3, 5'd1, 5'd0), mk(6'b000000, 5'd5, 5'd2, 5'd3), 1'b1);
        run_pair("ld_st", mk(6'b010100, 5'd6, 5'd1, 5'd0), mk(6'b010101, 5'd6, 5'd2, 5'd0), 1'b1);
    endtask

    task automatic test_no_hazard();
        run_pair("ld_r0", mk(6'b010100, 5'd0, 5'd1, 5'd0), mk(6'b000000, 5'd5, 5'd0, 5'd0), 1'b0);
        run_pair("ld_r7", mk(6'b010100, 5'd4, 5'd1, 5'd0), mk(6'b000000, 5'd5, 5'd7, 5'd7), 1'b0);
        run_pair("imm_rb", mk(6'b010100, 5'd3, 5'd1, 5'd0), mk(6'b001000, 5'd5, 5'd2, 5'd3), 1'b0);
    endtask

    task automatic test_back_to_back();
        run_pair("ld_ld", mk(6'b010100, 5'd4, 5'd1, 5'd0), mk(6'b010100, 5'd5, 5'd2, 5'd0), 1'b0);
    endtask

    task automatic test_mem_busy();
        logic [31:0] x;
        logic [31:0] v [5];
        x = mk(6'b000000, 5'd9, 5'd8, 5'd7);
        for (int i = 0; i < 5; i++) v[i] = mk(6'b000001, 5'(10 + i), 5'(i), 5'(i + 1));
        in_valid = 1; in_ins = x; exp_q.push_back(x);
        tick();
        in_valid = 0;
        tick();
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_ins = v[i]; exp_q.push_back(v[i]);
            tick();
        end
        in_ins = v[4]; exp_q.push_back(v[4]);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready !== 1'b0 || ins !== x || ins_valid !== 1'b1) begin
                failures++;
                $display("FAIL busy_freeze got rdy=%b ins=%h v=%b expected 0/%h/1", in_ready, ins, ins_valid, x);
            end
            tick();
        end
        mem_busy = 0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL busy_release_ready got=%b expected=1", in_ready);
        end
        tick();
        in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (exp_q.size() != 0 || ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_drain got pending=%0d v=%b expected 0/0", exp_q.size(), ins_valid);
        end
    endtask

    task automatic test_flush();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_ins = mk(6'b000010, 5'(20 + i), 5'd1, 5'd2);
            tick();
        end
        flush = 1; in_ins = mk(6'b000011, 5'd30, 5'd1, 5'd2);
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (ins !== 32'b0 || ins_valid !== 1'b0 || bubble !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin
            failures++;
            $display("FAIL flush_state got ins=%h v=%b b=%b rdy=%b cnt=%0d expected 0/0/0/1/%0d",
                     ins, ins_valid, bubble, in_ready, stall_cnt, exp_stall);
        end
        mem_busy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ins_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_empty got ins_valid=%b expected 0", ins_valid);
            end
        end
    endtask

    task automatic test_saturation();
        reset = 1;
        tick();
        reset = 0;
        exp_stall = 0;
        for (int i = 0; i < 4; i++)
            run_pair("sat", mk(6'b010100, 5'd4, 5'd1, 5'd0), mk(6'b000000, 5'd5, 5'd4, 5'd2), 1'b1);
        checks++;
        if (stall_cnt_s !== 2'd3) begin
            failures++;
            $display("FAIL stall_saturate got=%0d expected=3", stall_cnt_s);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_load_use();
        test_no_hazard();
        test_back_to_back();
        test_mem_busy();
        test_flush();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Instruction issue controller in front of dependency_Module.
- Buffers fetched instructions in a DEPTH-entry FIFO and issues one per cycle on ins.
- Inserts a single NOP bubble on a load-use hazard; ALU-result hazards are left to the dependency module's forwarding.
- Stalls when data memory reports busy, clears on flush, and counts bubbles for performance measurement.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_ins  in  32  fetched instruction
in_valid  in  1  in_ins is valid
in_ready  out  1  FIFO can accept; push = in_valid & in_ready & !flush
mem_busy  in  1  data memory busy; freezes issue
flush  in  1  redirect; discards all buffered and issued-pending state
ins  out  32  instruction to dependency_Module (registered)
ins_valid  out  1  ins is a real instruction (0 = bubble or idle)
bubble  out  1  registered; 1 for the cycle a hazard NOP is presented
stall_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Instruction fields:
  - op = [31:26], RW = [25:21], RA = [20:16], RB = [15:11], imm = [15:0].
  - Sources: RA always. RB when op[5:3]==3'b000. RW when op==OP_ST.
- Reset, sampled on the clk edge:
  - FIFO emptied.
  - ins=32'b0, ins_valid=0, bubble=0, stall_cnt=0.
  - Shadow cleared: last_ld=0, last_rw=0.
  - in_ready=1 from the first cycle after reset.
  - Pushes during a reset cycle are ignored.
- in_ready = (count < DEPTH), combinational from the registered count. There is no bypass when full.
- Push latency: an instruction pushed at edge N appears on ins at the earliest after edge N+1. The FIFO is never bypassed.
- Advance cycle = !mem_busy & !flush. On each advance edge:
  - hazard = last_ld & (last_rw != 0) & (last_rw matches any source of the FIFO head).
  - FIFO non-empty, no hazard: pop head. ins<=head, ins_valid<=1, bubble<=0. last_ld<=(head.op==OP_LD), last_rw<=head.RW.
  - FIFO non-empty, hazard: no pop. ins<=NOP_INS (32'b0), ins_valid<=0, bubble<=1. last_ld<=0. stall_cnt increments, saturating at all-ones.
  - FIFO empty: ins<=NOP_INS, ins_valid<=0, bubble<=0, last_ld<=0.
- mem_busy=1, no flush:
  - ins, ins_valid, bubble, shadow and stall_cnt hold.
  - No pop. Pushes still accepted while not full.
- flush=1, overrides mem_busy:
  - FIFO emptied.
  - ins<=NOP_INS, ins_valid<=0, bubble<=0, shadow cleared.
  - Push that cycle ignored. stall_cnt unchanged.
- Push and pop in the same edge: count unchanged, order preserved.
- A hazard inserts exactly one bubble. After a bubble last_ld=0, so the held head issues on the next advance cycle.
- Back-to-back loads to different registers never stall.
- RW=r0 never creates a hazard.

Decomposition:
- Package issue_pkg:
  - OP_LD=6'b010100, OP_ST=6'b010101, NOP_INS=32'b0.
  - Field bit-position constants.
  - Functions uses_rb(op) and src_match(ins, rw).
- Sub-module ins_fifo:
  - Synchronous FIFO, width 32, parameter DEPTH.
  - Ports: push, pop, dout, count, full, empty.
  - Synchronous active-high reset, clears count and pointers.
- issue_ctrl holds the issue register, hazard shadow and stall counter.

Test Plan:
1. Reset with in_valid=1 and in_ins=32'hFFFFFFFF, held 2 cycles -> ins=0, ins_valid=0, bubble=0, stall_cnt=0, in_ready=1; nothing issues after reset deasserts.
2. Push 000000_00001_00010_00011_00000000000 then 000100_00101_00001_00100_00000000000 on consecutive cycles -> issued on consecutive cycles with ins_valid=1, bubble never 1, stall_cnt=0.
3. Push LD 010100_00100_00001_00000_00000000000 then 000000_00101_00100_00010_00000000000 (RA=r4) -> cycle after the LD issue: ins=0, ins_valid=0, bubble=1; next cycle the add issues; stall_cnt=1.
4. Repeat scenario 3 with LD RW=r0, and separately with the consumer using r7 -> no bubble, stall_cnt stays 0.
5. mem_busy=1, offer 5 instructions -> 4 accepted, in_ready=0 after the 4th, ins frozen; release mem_busy -> all 5 issue in push order, in_ready returns to 1 after the first pop.
6. With 3 entries buffered and mem_busy=1, pulse flush -> next cycle ins=0, ins_valid=0, in_ready=1, FIFO empty. With CNT_W=2, force 4 hazards -> stall_cnt saturates at 3.
